// File: rtl/imm_gen_stage.sv
// ============================================================================
// Module   : imm_gen_stage
// Purpose  : Registered RV32I/Zicsr immediate generator with PC-relative
//            target precompute behind a 2-entry valid/ready skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen_stage #(
    parameter int XLEN   = 32,
    parameter bit CSR_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic [XLEN-1:0] out_target,
    output logic            out_target_vld,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;
    localparam logic [2:0] IMM_Z    = 3'd6;

    // Bundle layout: {pc, target, imm, type, target_vld, illegal}
    localparam int BW = 3*XLEN + 5;

    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_target;
    logic [2:0]      w_type;
    logic            w_tvld;
    logic            w_ill;
    logic [BW-1:0]   w_dec;

    always_comb begin
        w_imm32 = 32'd0;
        w_type  = IMM_NONE;
        w_tvld  = 1'b0;
        w_ill   = 1'b0;
        case (in_inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                w_type  = IMM_I;
            end
            7'b0100011: begin
                w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                w_type  = IMM_S;
            end
            7'b1100011: begin
                w_imm32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25],
                           in_inst[11:8], 1'b0};
                w_type  = IMM_B;
                w_tvld  = 1'b1;
            end
            7'b0110111: begin
                w_imm32 = {in_inst[31:12], 12'd0};
                w_type  = IMM_U;
            end
            7'b0010111: begin
                w_imm32 = {in_inst[31:12], 12'd0};
                w_type  = IMM_U;
                w_tvld  = 1'b1;
            end
            7'b1101111: begin
                w_imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20],
                           in_inst[30:21], 1'b0};
                w_type  = IMM_J;
                w_tvld  = 1'b1;
            end
            7'b1110011: begin
                if (CSR_EN) begin
                    w_imm32 = {27'd0, in_inst[19:15]};
                    w_type  = IMM_Z;
                end else begin
                    w_ill   = 1'b1;
                end
            end
            7'b0110011: begin
                w_type  = IMM_NONE;
            end
            default: begin
                w_ill   = 1'b1;
            end
        endcase
    end

    // Every 32-bit immediate already carries its correct sign in bit 31
    // (zimm is zero-extended there), so one signed widening covers XLEN=64.
    assign w_imm    = XLEN'($signed(w_imm32));
    assign w_target = w_tvld ? (in_pc + w_imm) : '0;
    assign w_dec    = {in_pc, w_target, w_imm, w_type, w_tvld, w_ill};

    logic          out_valid_q, out_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          in_ready_q, in_ready_d;
    logic [BW-1:0] out_data_q, out_data_d;
    logic [BW-1:0] skid_data_q, skid_data_d;
    logic          w_accept;
    logic          w_out_free;

    // rst only masks the registered ready; there is no path from out_ready.
    assign in_ready   = in_ready_q & ~rst;
    assign w_accept   = in_valid & in_ready;
    assign w_out_free = ~out_valid_q | out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_data_d   = out_data_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (w_out_free) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (w_accept) begin
                out_data_d   = w_dec;
                out_valid_d  = 1'b1;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (w_accept) begin
            skid_data_d  = w_dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            out_data_q   <= '0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            out_data_q   <= out_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_pc         = out_data_q[3*XLEN+4 -: XLEN];
    assign out_target     = out_data_q[2*XLEN+4 -: XLEN];
    assign out_imm        = out_data_q[XLEN+4 -: XLEN];
    assign out_imm_type   = out_data_q[4:2];
    assign out_target_vld = out_data_q[1];
    assign out_illegal    = out_data_q[0];

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
// ============================================================================
// Module   : tb_imm_gen_stage
// Purpose  : Directed self-checking bench for imm_gen_stage (XLEN 32/64,
//            CSR_EN 0/1 instances share one stimulus stream).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;
    logic [63:0] pc64;

    logic        in_ready, out_valid, out_tvld, out_ill;
    logic [31:0] out_imm, out_target, out_pc;
    logic [2:0]  out_type;

    logic        r64_ready, r64_valid, r64_tvld, r64_ill;
    logic [63:0] r64_imm, r64_target, r64_pc;
    logic [2:0]  r64_type;

    logic        nc_ready, nc_valid, nc_tvld, nc_ill;
    logic [31:0] nc_imm, nc_target, nc_pc;
    logic [2:0]  nc_type;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;
    assign pc64 = {32'd0, in_pc};

    imm_gen_stage #(.XLEN(32), .CSR_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_imm_type(out_type), .out_target(out_target), .out_target_vld(out_tvld),
        .out_illegal(out_ill), .out_pc(out_pc)
    );

    imm_gen_stage #(.XLEN(64), .CSR_EN(1'b1)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(r64_ready), .in_inst(in_inst), .in_pc(pc64),
        .out_valid(r64_valid), .out_ready(out_ready), .out_imm(r64_imm),
        .out_imm_type(r64_type), .out_target(r64_target), .out_target_vld(r64_tvld),
        .out_illegal(r64_ill), .out_pc(r64_pc)
    );

    imm_gen_stage #(.XLEN(32), .CSR_EN(1'b0)) dutnc (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(nc_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(nc_valid), .out_ready(out_ready), .out_imm(nc_imm),
        .out_imm_type(nc_type), .out_target(nc_target), .out_target_vld(nc_tvld),
        .out_illegal(nc_ill), .out_pc(nc_pc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addi(input int k);
        logic [11:0] imm12;
        imm12 = 12'(k);
        return {imm12, 5'd0, 3'b000, 5'd1, 7'b0010011};
    endfunction

    initial begin
        int next_in;
        int next_out;
        logic acc;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'd0; in_pc = 32'd0;
        tick(); tick();
        chk("rst_in_ready",  64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_imm",   64'(out_imm), 64'd0);
        chk("rst_out_pc",    64'(out_pc), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready",  64'(in_ready), 64'd1);

        // addi x1,x0,-1
        out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h0;
        tick();
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_imm",   64'(out_imm), 64'hFFFFFFFF);
        chk("addi_type",  64'(out_type), 64'd1);
        chk("addi_tvld",  64'(out_tvld), 64'd0);
        chk("addi_ill",   64'(out_ill), 64'd0);
        chk("addi_imm64", r64_imm, 64'hFFFFFFFFFFFFFFFF);

        // beq -4 at 0x100
        in_inst = 32'hFE000EE3; in_pc = 32'h100;
        tick();
        chk("beq_imm",    64'(out_imm), 64'hFFFFFFFC);
        chk("beq_type",   64'(out_type), 64'd3);
        chk("beq_target", 64'(out_target), 64'hFC);
        chk("beq_tvld",   64'(out_tvld), 64'd1);
        chk("beq_pc",     64'(out_pc), 64'h100);
        chk("beq_tgt64",  r64_target, 64'hFC);

        // jal +8 at 0x200
        in_inst = 32'h0080006F; in_pc = 32'h200;
        tick();
        chk("jal_imm",    64'(out_imm), 64'h8);
        chk("jal_type",   64'(out_type), 64'd5);
        chk("jal_target", 64'(out_target), 64'h208);

        // lui 0x12345
        in_inst = 32'h123450B7;
        tick();
        chk("lui_imm",    64'(out_imm), 64'h12345000);
        chk("lui_type",   64'(out_type), 64'd4);
        chk("lui_tvld",   64'(out_tvld), 64'd0);
        chk("lui_target", 64'(out_target), 64'd0);

        // lui 0x80000 -> sign from bit 31 on the 64-bit instance
        in_inst = 32'h800000B7;
        tick();
        chk("lui_neg_imm",   64'(out_imm), 64'h80000000);
        chk("lui_neg_imm64", r64_imm, 64'hFFFFFFFF80000000);

        // auipc x0,1 at 0x1000
        in_inst = 32'h00001017; in_pc = 32'h1000;
        tick();
        chk("auipc_imm",    64'(out_imm), 64'h1000);
        chk("auipc_target", 64'(out_target), 64'h2000);
        chk("auipc_tvld",   64'(out_tvld), 64'd1);

        // store sw x2,-8(x1): imm=-8 -> {1111111,11000}
        in_inst = 32'hFE20AC23;
        tick();
        chk("sw_imm",  64'(out_imm), 64'hFFFFFFF8);
        chk("sw_type", 64'(out_type), 64'd2);

        // csrrwi zimm=5
        in_inst = 32'h3002D073;
        tick();
        chk("csr_imm",    64'(out_imm), 64'h5);
        chk("csr_type",   64'(out_type), 64'd6);
        chk("csr_ill",    64'(out_ill), 64'd0);
        chk("csr_nc_ill", 64'(nc_ill), 64'd1);
        chk("csr_nc_imm", 64'(nc_imm), 64'd0);

        // add x3,x1,x2 (legal, no immediate)
        in_inst = 32'h002081B3;
        tick();
        chk("op_type", 64'(out_type), 64'd0);
        chk("op_ill",  64'(out_ill), 64'd0);
        chk("op_imm",  64'(out_imm), 64'd0);

        // unknown opcode
        in_inst = 32'h0000007F;
        tick();
        chk("bad_ill",  64'(out_ill), 64'd1);
        chk("bad_imm",  64'(out_imm), 64'd0);
        chk("bad_type", 64'(out_type), 64'd0);

        in_valid = 1'b0;
        tick();
        chk("idle_valid", 64'(out_valid), 64'd0);

        // Stream of 5 with a 3-cycle downstream stall
        next_in = 0; next_out = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid  = (next_in < 5);
            in_inst   = addi(next_in + 1);
            #1;
            if (cyc == 2) begin
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_valid",    64'(out_valid), 64'd1);
                chk("stall_hold_imm", 64'(out_imm), 64'd1);
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk("stream_order", 64'(out_imm), 64'(next_out + 1));
                next_out++;
            end
            tick();
            if (acc) next_in++;
        end
        in_valid = 1'b0;
        chk("stream_count", 64'(next_out), 64'd5);
        chk("stream_empty", 64'(out_valid), 64'd0);

        // Flush with both entries full and a new input pending
        out_ready = 1'b0; in_valid = 1'b1;
        in_inst = addi(7); tick();
        in_inst = addi(8); tick();
        chk("full_in_ready", 64'(in_ready), 64'd0);
        flush = 1'b1; in_inst = addi(9);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid",    64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        tick(); tick();
        chk("flush_gone", 64'(out_valid), 64'd0);

        // Input presented during flush with an empty stage is dropped
        flush = 1'b1; in_valid = 1'b1; in_inst = addi(10);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_drop", 64'(out_valid), 64'd0);

        // Reset mid-stall
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h400;
        in_inst = 32'hFE000EE3; tick();
        in_inst = 32'h0080006F; tick();
        rst = 1'b1; in_valid = 1'b0;
        tick();
        chk("mrst_valid",    64'(out_valid), 64'd0);
        chk("mrst_imm",      64'(out_imm), 64'd0);
        chk("mrst_target",   64'(out_target), 64'd0);
        chk("mrst_pc",       64'(out_pc), 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0; out_ready = 1'b1;
        tick();
        chk("mrst_after_valid", 64'(out_valid), 64'd0);
        chk("mrst_after_ready", 64'(in_ready), 64'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

`default_nettype wire
